// File: rtl/pool_2x2.sv
// 2x2 average pooling over a raster-ordered frame with valid/ready handshakes.
// Even rows store horizontal pair sums in a half-width line buffer; odd rows
// combine the stored pair with the current pair and emit floor(sum / 4).
module pool_2x2 #(
    parameter int unsigned PIXEL_BIT_WIDTH = 16,
    parameter int unsigned IN_ROWS         = 48,
    parameter int unsigned IN_COLS         = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned W       = PIXEL_BIT_WIDTH;
    localparam int unsigned LbDepth = IN_COLS / 2;
    localparam int unsigned ColW    = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int unsigned RowW    = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int unsigned AddrW   = (LbDepth > 1) ? $clog2(LbDepth) : 1;

    logic [ColW-1:0]  col_q;
    logic [RowW-1:0]  row_q;
    logic [W-1:0]     hold_q;
    logic [W:0]       lb_q [LbDepth];
    logic [W-1:0]     out_q;
    logic             out_valid_q;

    logic             accept;
    logic             odd_col;
    logic             odd_row;
    logic             last_col;
    logic             last_row;
    logic             lb_write;
    logic             window_done;
    logic [AddrW-1:0] lb_addr;
    logic [W:0]       lb_rd;
    logic [W:0]       pair_sum;
    logic [W+1:0]     quad_sum;

    // Downstream stall blocks intake only while an unconsumed result is held.
    assign in_ready    = !reset && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;

    assign odd_col     = col_q[0];
    assign odd_row     = row_q[0];
    assign last_col    = (col_q == ColW'(IN_COLS - 1));
    assign last_row    = (row_q == RowW'(IN_ROWS - 1));
    assign lb_addr     = AddrW'(col_q >> 1);
    assign lb_rd       = lb_q[lb_addr];

    assign lb_write    = accept && odd_col && !odd_row;
    assign window_done = accept && odd_col && odd_row;

    // Sign-extended sums are wide enough that neither can overflow.
    assign pair_sum    = {hold_q[W-1], hold_q} + {pixel_in[W-1], pixel_in};
    assign quad_sum    = {lb_rd[W], lb_rd}
                       + {{2{hold_q[W-1]}}, hold_q}
                       + {{2{pixel_in[W-1]}}, pixel_in};

    assign pixel_out   = out_q;
    assign out_valid   = out_valid_q;

    // Raster position of the next accepted pixel; wraps so frames run back to back.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + RowW'(1);
            end else begin
                col_q <= col_q + ColW'(1);
            end
        end
    end

    // Holds the even-column pixel until its odd-column partner arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (accept && !odd_col) begin
            hold_q <= pixel_in;
        end
    end

    // Line buffer of even-row pair sums; every entry is rewritten before any odd-row read.
    always_ff @(posedge clk) begin
        if (lb_write) begin
            lb_q[lb_addr] <= pair_sum;
        end
    end

    // Output register: load on window completion, else drop once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (window_done) begin
            out_valid_q <= 1'b1;
            // Dropping the two LSBs of the signed sum is floor division by 4.
            out_q       <= quad_sum[W+1:2];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_2x2.sv
// Self-checking bench for pool_2x2: window table, ramp, constant, stall,
// random-handshake and mid-frame-reset scenarios against a frame-level model.
module tb_pool_2x2;

    localparam int R  = 48;
    localparam int C  = 48;
    localparam int FP = R * C;
    localparam int FO = FP / 4;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pixel_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pixel_out;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int stim[$];
    int got[$];
    int exp_q[$];
    int refused;
    int stall_viol;
    int stall_seen;

    pool_2x2 #(
        .PIXEL_BIT_WIDTH(16),
        .IN_ROWS        (R),
        .IN_COLS        (C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pixel_in (pixel_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pixel_out(pixel_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_div4(input int s);
        int q;
        q = s / 4;
        if ((s % 4) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int at(input int i);
        if (i < got.size()) return got[i];
        return -999999;
    endfunction

    // Reference: average each 2x2 block of each frame held in stim.
    task automatic build_model();
        int nf;
        int base;
        exp_q.delete();
        nf = stim.size() / FP;
        for (int f = 0; f < nf; f++) begin
            base = f * FP;
            for (int rr = 0; rr < R / 2; rr++) begin
                for (int cc = 0; cc < C / 2; cc++) begin
                    exp_q.push_back(floor_div4(stim[base + (2*rr)*C + 2*cc]
                                             + stim[base + (2*rr)*C + 2*cc + 1]
                                             + stim[base + (2*rr+1)*C + 2*cc]
                                             + stim[base + (2*rr+1)*C + 2*cc + 1]));
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int n;
        build_model();
        check({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_out%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_in_ready_low", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_pixel_out", int'(pixel_out), 0);
        check("reset_in_ready_high", int'(in_ready), 1);
    endtask

    // Streams stim[0..n_pix-1] and collects outputs. out_ready is held low for
    // the first `stall` cycles; `abort` stops right after the last acceptance.
    task automatic run(input int n_pix, input int valid_pct, input int ready_pct,
                       input int stall, input bit abort);
        int  idx;
        int  cyc;
        int  budget;
        bit  acc;
        idx        = 0;
        cyc        = 0;
        budget     = n_pix * 10 + 2000 + stall;
        refused    = 0;
        stall_viol = 0;
        stall_seen = 0;
        got.delete();
        forever begin
            @(negedge clk);
            in_valid  = (idx < n_pix) && ($urandom_range(99) < valid_pct);
            pixel_in  = in_valid ? 16'(stim[idx]) : 16'($urandom);
            out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < ready_pct);
            #1;
            if (cyc < stall) begin
                if (out_valid) stall_seen = 1;
                if (out_valid && in_ready) stall_viol++;
                if (!out_valid && stall_seen == 0 && !in_ready) stall_viol++;
            end
            if (in_valid && !in_ready) refused++;
            acc = in_valid && in_ready;
            if (acc) idx++;
            if (out_valid && out_ready) got.push_back(int'($signed(pixel_out)));
            cyc++;
            if (abort && idx == n_pix) break;
            if (idx == n_pix && !acc && !out_valid) break;
            if (cyc > budget) begin
                check("run_timeout", cyc, budget);
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic load_ramp();
        stim.delete();
        for (int i = 0; i < FP; i++) stim.push_back(i);
    endtask

    initial begin
        vec_t tbl[10];
        int   bad;

        tbl[0] = '{-1, -1, -1, -2, -2};
        tbl[1] = '{32767, 32767, 32767, 32767, 32767};
        tbl[2] = '{-32768, -32768, -32768, -32768, -32768};
        tbl[3] = '{1, 2, 3, 4, 2};
        tbl[4] = '{-1, -2, -3, -4, -3};
        tbl[5] = '{32767, 32767, -32768, -32768, -1};
        tbl[6] = '{-1, 0, 0, 0, -1};
        tbl[7] = '{3, 0, 0, 0, 0};
        tbl[8] = '{100, -100, 7, -8, -1};
        tbl[9] = '{5, 5, 5, 6, 5};

        do_reset();

        // Window table: vector k occupies columns 2k,2k+1 of rows 0 and 1.
        stim.delete();
        for (int i = 0; i < FP; i++) stim.push_back(0);
        for (int k = 0; k < 10; k++) begin
            stim[2*k]       = tbl[k].a;
            stim[2*k + 1]   = tbl[k].b;
            stim[C + 2*k]   = tbl[k].c;
            stim[C + 2*k+1] = tbl[k].d;
        end
        run(FP, 100, 100, 0, 1'b0);
        check("table_count", got.size(), FO);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("window%0d", k), at(k), tbl[k].exp);
        end

        // Constant 8 at full throughput: nothing refused, every output 8.
        stim.delete();
        for (int i = 0; i < FP; i++) stim.push_back(8);
        run(FP, 100, 100, 0, 1'b0);
        check("const8_no_refusal", refused, 0);
        check("const8_count", got.size(), FO);
        bad = 0;
        foreach (got[i]) if (got[i] != 8) bad++;
        check("const8_values", bad, 0);

        // Ramp frame with known closed-form outputs.
        load_ramp();
        run(FP, 100, 100, 0, 1'b0);
        check("ramp_0_0", at(0), 24);
        check("ramp_0_1", at(1), 26);
        check("ramp_1_0", at(24), 120);
        check("ramp_23_23", at(575), 2278);
        compare_all("ramp");

        // Long downstream stall: in_ready must drop once the first result waits.
        load_ramp();
        run(FP, 100, 100, 300, 1'b0);
        check("stall_out_seen", stall_seen, 1);
        check("stall_in_ready", stall_viol, 0);
        compare_all("stall");

        // Three frames of random pixels with random handshakes.
        stim.delete();
        for (int i = 0; i < 3 * FP; i++) stim.push_back(int'($urandom_range(65535)) - 32768);
        run(3 * FP, 50, 50, 0, 1'b0);
        compare_all("rand");

        // Abandon a frame at pixel 1000, reset, then a clean ramp frame.
        load_ramp();
        run(1000, 100, 100, 0, 1'b1);
        do_reset();
        load_ramp();
        run(FP, 100, 100, 0, 1'b0);
        check("post_reset_first", at(0), 24);
        compare_all("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
